// File: rtl/tm_cpu_pipe_ctrl.sv
// TM-side endpoint of the CPU timing-token interface: round-robin token issue, ld/st stall modelling.
// Optional per-thread retire counters are built when TM_RETIRE_CNT_EN is defined.
module tm_cpu_pipe_ctrl #(
    parameter int NTHREAD      = 64,
    parameter int MEM_LAT      = 4,
    parameter int CNT_W        = 32,
    localparam int NTHREADIDMSB = $clog2(NTHREAD) - 1
) (
    input  logic                  gclk,
    input  logic                  rst,
    input  logic [NTHREADIDMSB:0] threads_active,
    input  logic [NTHREADIDMSB:0] threads_total,
    input  logic [2:0]            tm_dbg_ctrl,
    input  logic                  fm_valid,
    input  logic [NTHREADIDMSB:0] fm_tid,
    input  logic                  fm_run,
    input  logic                  fm_replay,
    input  logic                  fm_retired,
    input  logic [31:0]           fm_inst,
    output logic                  tm_valid,
    output logic                  tm_run,
    output logic [NTHREADIDMSB:0] tm_tid,
    output logic                  tm_running,
    input  logic [NTHREADIDMSB:0] cnt_tid,
    output logic [CNT_W-1:0]      cnt_val
);

    localparam int TID_W = NTHREADIDMSB + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    state_e           state_q, state_d;
    logic [TID_W-1:0] ptr_q, ptr_d;
    logic [TID_W:0]   drain_cnt_q, drain_cnt_d;
    logic [3:0]       stall_q [NTHREAD];
    logic             tm_valid_q, tm_run_q, tm_running_q;
    logic [TID_W-1:0] tm_tid_q;

    logic             issue, start_cmd, stop_cmd, retire, ld_st;
    logic             tm_run_d;
    logic [TID_W:0]   total_eff;

    always_comb begin
        total_eff = (threads_total == '0) ? (TID_W+1)'(1) : {1'b0, threads_total};
        issue     = (state_q != ST_IDLE);
        start_cmd = (tm_dbg_ctrl == 3'd1) || (tm_dbg_ctrl == 3'd3);
        stop_cmd  = (tm_dbg_ctrl == 3'd2) || (tm_dbg_ctrl == 3'd4);
        retire    = fm_valid & fm_run & ~fm_replay & fm_retired;
        ld_st     = retire & (fm_inst[31:30] == 2'b11);

        // Wrap test uses >= so a pointer beyond a shrunken thread count also returns to 0.
        ptr_d = ptr_q;
        if (issue) begin
            if (({1'b0, ptr_q} + 1'b1) >= total_eff) ptr_d = '0;
            else                                     ptr_d = ptr_q + 1'b1;
        end

        tm_run_d = (state_q == ST_RUN) && (ptr_q < threads_active) && (stall_q[ptr_q] == 4'd0);

        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE:  if (start_cmd) state_d = ST_RUN;
            ST_RUN: begin
                if (stop_cmd) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (start_cmd)                            state_d = ST_RUN;
                else if ((drain_cnt_q + 1'b1) >= total_eff) state_d = ST_IDLE;
                else                                      drain_cnt_d = drain_cnt_q + 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge gclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            drain_cnt_q  <= '0;
            tm_valid_q   <= 1'b0;
            tm_run_q     <= 1'b0;
            tm_tid_q     <= '0;
            tm_running_q <= 1'b0;
            // NOTE: the stall table must be cleared on reset so a restarted thread never inherits a stall.
            for (int i = 0; i < NTHREAD; i++) stall_q[i] <= 4'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            drain_cnt_q  <= drain_cnt_d;
            tm_valid_q   <= issue;
            tm_run_q     <= tm_run_d;
            tm_tid_q     <= ptr_q;
            tm_running_q <= (state_d == ST_RUN);
            // A ld/st retire reloads the stall even if the same thread is issuing this cycle.
            for (int i = 0; i < NTHREAD; i++) begin
                if (ld_st && (fm_tid == TID_W'(i)))
                    stall_q[i] <= 4'(MEM_LAT);
                else if (issue && (ptr_q == TID_W'(i)) && (stall_q[i] != 4'd0))
                    stall_q[i] <= stall_q[i] - 4'd1;
            end
        end
    end

    assign tm_valid   = tm_valid_q;
    assign tm_run     = tm_run_q;
    assign tm_tid     = tm_tid_q;
    assign tm_running = tm_running_q;

`ifdef TM_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q [NTHREAD];
    logic [CNT_W-1:0] cnt_val_q;

    always_ff @(posedge gclk) begin
        if (rst) begin
            cnt_val_q <= '0;
            for (int i = 0; i < NTHREAD; i++) cnt_q[i] <= '0;
        end else begin
            cnt_val_q <= cnt_q[cnt_tid];
            for (int i = 0; i < NTHREAD; i++)
                if (retire && (fm_tid == TID_W'(i))) cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end

    assign cnt_val = cnt_val_q;

    logic unused_bits;
    assign unused_bits = ^fm_inst[29:0];
`else
    assign cnt_val = '0;

    logic unused_bits;
    assign unused_bits = ^{fm_inst[29:0], cnt_tid};
`endif

endmodule

// File: tb/tb_tm_cpu_pipe_ctrl.sv
// Directed bench for tm_cpu_pipe_ctrl: issue order, stalls, drain, reset, total changes, retire counters.
module tb_tm_cpu_pipe_ctrl;

    localparam int NTHREAD = 64;
    localparam int TID_W   = 6;
`ifdef TM_RETIRE_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    logic             gclk = 1'b0;
    logic             rst;
    logic [TID_W-1:0] threads_active, threads_total;
    logic [2:0]       tm_dbg_ctrl;
    logic             fm_valid, fm_run, fm_replay, fm_retired;
    logic [TID_W-1:0] fm_tid;
    logic [31:0]      fm_inst;
    logic             tm_valid, tm_run, tm_running;
    logic [TID_W-1:0] tm_tid;
    logic [TID_W-1:0] cnt_tid;
    logic [CNT_W-1:0] cnt_val;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tm_cpu_pipe_ctrl #(.NTHREAD(NTHREAD), .MEM_LAT(4), .CNT_W(CNT_W)) dut (
        .gclk(gclk), .rst(rst),
        .threads_active(threads_active), .threads_total(threads_total),
        .tm_dbg_ctrl(tm_dbg_ctrl),
        .fm_valid(fm_valid), .fm_tid(fm_tid), .fm_run(fm_run), .fm_replay(fm_replay),
        .fm_retired(fm_retired), .fm_inst(fm_inst),
        .tm_valid(tm_valid), .tm_run(tm_run), .tm_tid(tm_tid), .tm_running(tm_running),
        .cnt_tid(cnt_tid), .cnt_val(cnt_val)
    );

    always #5 gclk = ~gclk;

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    task automatic fm_tok(input logic [TID_W-1:0] tid, input logic run, input logic replay,
                          input logic [31:0] inst);
        fm_valid   = 1'b1;
        fm_tid     = tid;
        fm_run     = run;
        fm_replay  = replay;
        fm_retired = 1'b1;
        fm_inst    = inst;
    endtask

    task automatic fm_clear();
        fm_valid = 1'b0; fm_run = 1'b0; fm_replay = 1'b0; fm_retired = 1'b0; fm_inst = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tm_dbg_ctrl = 3'd0; threads_active = 6'd4; threads_total = 6'd4;
        fm_clear();
        step();
        rst = 1'b0;
    endtask

    task automatic start_run();
        tm_dbg_ctrl = 3'd1;
        step();
        tm_dbg_ctrl = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tm_dbg_ctrl = 3'd0; threads_active = 6'd4; threads_total = 6'd4;
        cnt_tid = '0; fm_clear(); fm_tid = '0;
        step(); step();
        total_cnt++;
        if ({tm_valid, tm_run, tm_tid, tm_running} !== 9'd0)
            $display("FAIL reset_outputs got v=%0b r=%0b tid=%0d running=%0b want all 0",
                     tm_valid, tm_run, tm_tid, tm_running);
        else pass_cnt++;
        total_cnt++;
        if (cnt_val !== '0) $display("FAIL reset_cnt_val got %0d want 0", cnt_val);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        start_run();
        total_cnt++;
        if ({tm_running, tm_valid} !== 2'b10)
            $display("FAIL rr_start got running=%0b v=%0b want running=1 v=0", tm_running, tm_valid);
        else pass_cnt++;
        for (int n = 0; n < 8; n++) begin
            step();
            total_cnt++;
            if ({tm_valid, tm_run, tm_tid} !== {2'b11, 6'(n % 4)})
                $display("FAIL rr_token%0d got v=%0b r=%0b tid=%0d want v=1 r=1 tid=%0d",
                         n, tm_valid, tm_run, tm_tid, n % 4);
            else pass_cnt++;
        end
    endtask

    task automatic test_active();
        logic exp_run;
        do_reset();
        threads_active = 6'd2;
        start_run();
        for (int n = 0; n < 8; n++) begin
            step();
            exp_run = (n % 4) < 2;
            total_cnt++;
            if ({tm_valid, tm_run, tm_tid} !== {1'b1, exp_run, 6'(n % 4)})
                $display("FAIL active_token%0d got v=%0b r=%0b tid=%0d want v=1 r=%0b tid=%0d",
                         n, tm_valid, tm_run, tm_tid, exp_run, n % 4);
            else pass_cnt++;
        end
        threads_active = 6'd4;
    endtask

    // Token n (n>=1) after the retire edge carries tid n%4; tid1 is stalled until index last_stall.
    task automatic stall_scan(input string name, input int n_max, input int first_run, input int reload_at);
        logic exp_run;
        for (int n = 1; n <= n_max; n++) begin
            if (n == reload_at) fm_tok(6'd1, 1'b1, 1'b0, 32'hC000_0000);
            step();
            fm_clear();
            exp_run = ((n % 4) != 1) || (n >= first_run);
            total_cnt++;
            if ({tm_valid, tm_run, tm_tid} !== {1'b1, exp_run, 6'(n % 4)})
                $display("FAIL %s_token%0d got v=%0b r=%0b tid=%0d want v=1 r=%0b tid=%0d",
                         name, n, tm_valid, tm_run, tm_tid, exp_run, n % 4);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        start_run();
        fm_tok(6'd1, 1'b1, 1'b0, 32'hC000_0000);
        step();
        fm_clear();
        stall_scan("stall", 20, 17, 0);
    endtask

    task automatic test_load_wins();
        do_reset();
        start_run();
        fm_tok(6'd1, 1'b1, 1'b0, 32'hC000_0000);
        step();
        fm_clear();
        stall_scan("loadwin", 28, 25, 5);
    endtask

    task automatic test_replay_ignored();
        do_reset();
        start_run();
        fm_tok(6'd2, 1'b1, 1'b1, 32'hC000_0000);
        step();
        fm_tok(6'd2, 1'b0, 1'b0, 32'hC000_0000);
        step();
        fm_tok(6'd2, 1'b1, 1'b0, 32'hC000_0000);
        fm_valid = 1'b0;
        step();
        fm_clear();
        for (int n = 3; n <= 8; n++) begin
            step();
            total_cnt++;
            if ({tm_valid, tm_run, tm_tid} !== {2'b11, 6'(n % 4)})
                $display("FAIL replay_token%0d got v=%0b r=%0b tid=%0d want v=1 r=1 tid=%0d",
                         n, tm_valid, tm_run, tm_tid, n % 4);
            else pass_cnt++;
        end
    endtask

    task automatic test_stop();
        do_reset();
        start_run();
        step(); step(); step();
        tm_dbg_ctrl = 3'd2;
        step();
        tm_dbg_ctrl = 3'd0;
        total_cnt++;
        if ({tm_running, tm_valid, tm_run, tm_tid} !== {3'b011, 6'd3})
            $display("FAIL stop_edge got running=%0b v=%0b r=%0b tid=%0d want running=0 v=1 r=1 tid=3",
                     tm_running, tm_valid, tm_run, tm_tid);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            step();
            total_cnt++;
            if ({tm_valid, tm_run, tm_tid} !== {2'b10, 6'(k)})
                $display("FAIL drain_token%0d got v=%0b r=%0b tid=%0d want v=1 r=0 tid=%0d",
                         k, tm_valid, tm_run, tm_tid, k);
            else pass_cnt++;
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 1) tm_dbg_ctrl = 3'd2;
            step();
            tm_dbg_ctrl = 3'd0;
            total_cnt++;
            if ({tm_valid, tm_running} !== 2'b00)
                $display("FAIL drain_idle%0d got v=%0b running=%0b want v=0 running=0", k, tm_valid, tm_running);
            else pass_cnt++;
        end
    endtask

    task automatic test_drain_abort();
        do_reset();
        tm_dbg_ctrl = 3'd3;
        step();
        tm_dbg_ctrl = 3'd0;
        step();
        tm_dbg_ctrl = 3'd4;
        step();
        total_cnt++;
        if ({tm_running, tm_valid, tm_run, tm_tid} !== {3'b011, 6'd1})
            $display("FAIL abort_stop got running=%0b v=%0b r=%0b tid=%0d want running=0 v=1 r=1 tid=1",
                     tm_running, tm_valid, tm_run, tm_tid);
        else pass_cnt++;
        tm_dbg_ctrl = 3'd0;
        step();
        tm_dbg_ctrl = 3'd1;
        step();
        total_cnt++;
        if ({tm_running, tm_valid, tm_run, tm_tid} !== {3'b110, 6'd3})
            $display("FAIL abort_start got running=%0b v=%0b r=%0b tid=%0d want running=1 v=1 r=0 tid=3",
                     tm_running, tm_valid, tm_run, tm_tid);
        else pass_cnt++;
        // start while already running is ignored
        step();
        tm_dbg_ctrl = 3'd0;
        step();
        total_cnt++;
        if ({tm_running, tm_valid, tm_run, tm_tid} !== {3'b111, 6'd1})
            $display("FAIL abort_resume got running=%0b v=%0b r=%0b tid=%0d want running=1 v=1 r=1 tid=1",
                     tm_running, tm_valid, tm_run, tm_tid);
        else pass_cnt++;
    endtask

    task automatic test_total_change();
        logic [TID_W-1:0] exp_tid [8];
        exp_tid = '{6'd3, 6'd0, 6'd1, 6'd0, 6'd1, 6'd0, 6'd0, 6'd0};
        do_reset();
        start_run();
        step(); step(); step();
        threads_total = 6'd2;
        for (int n = 0; n < 8; n++) begin
            if (n == 5) threads_total = 6'd0;
            step();
            total_cnt++;
            if ({tm_valid, tm_run, tm_tid} !== {2'b11, exp_tid[n]})
                $display("FAIL total_token%0d got v=%0b r=%0b tid=%0d want v=1 r=1 tid=%0d",
                         n, tm_valid, tm_run, tm_tid, exp_tid[n]);
            else pass_cnt++;
        end
        threads_total = 6'd4;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_run();
        fm_tok(6'd2, 1'b1, 1'b0, 32'hC000_0000);
        step();
        fm_clear();
        step(); step();
        total_cnt++;
        if ({tm_run, tm_tid} !== {1'b0, 6'd2})
            $display("FAIL midrst_stalled got r=%0b tid=%0d want r=0 tid=2", tm_run, tm_tid);
        else pass_cnt++;
        rst = 1'b1;
        step();
        total_cnt++;
        if ({tm_valid, tm_run, tm_tid, tm_running} !== 9'd0)
            $display("FAIL midrst_outputs got v=%0b r=%0b tid=%0d running=%0b want all 0",
                     tm_valid, tm_run, tm_tid, tm_running);
        else pass_cnt++;
        rst = 1'b0;
        start_run();
        step(); step(); step();
        total_cnt++;
        if ({tm_valid, tm_run, tm_tid} !== {2'b11, 6'd2})
            $display("FAIL midrst_restart got v=%0b r=%0b tid=%0d want v=1 r=1 tid=2",
                     tm_valid, tm_run, tm_tid);
        else pass_cnt++;
    endtask

    task automatic retire_burst(input int n);
        for (int i = 0; i < n; i++) begin
            fm_tok(6'd3, 1'b1, 1'b0, 32'h0000_0013);
            step();
            if (i < 2) begin
                fm_tok(6'd3, 1'b1, 1'b1, 32'h0000_0013);
                step();
            end
        end
        fm_clear();
        step();
    endtask

    task automatic test_retire_cnt();
        logic [CNT_W-1:0] exp5, exp0;
        do_reset();
        cnt_tid = 6'd3;
`ifdef TM_RETIRE_CNT_EN
        exp5 = CNT_W'(5);
`else
        exp5 = '0;
`endif
        exp0 = '0;
        retire_burst(5);
        total_cnt++;
        if (cnt_val !== exp5) $display("FAIL cnt_tid3 got %0d want %0d", cnt_val, exp5);
        else pass_cnt++;
        cnt_tid = 6'd2;
        step();
        total_cnt++;
        if (cnt_val !== exp0) $display("FAIL cnt_tid2 got %0d want 0", cnt_val);
        else pass_cnt++;
        cnt_tid = 6'd3;
        retire_burst((1 << CNT_W) - 5 > 64 ? 11 : (1 << CNT_W) - 5);
`ifdef TM_RETIRE_CNT_EN
        exp0 = '0;
`else
        exp0 = '0;
`endif
        total_cnt++;
        if (cnt_val !== exp0) $display("FAIL cnt_wrap got %0d want 0", cnt_val);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_active();
        test_stall();
        test_load_wins();
        test_replay_ignored();
        test_stop();
        test_drain_abort();
        test_total_change();
        test_reset_mid();
        test_retire_cnt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
